// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings, controller state type and width helpers for the
// status LED mode controller.
package led_ctrl_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'd0;
    localparam mode_t MODE_ON     = 2'd1;
    localparam mode_t MODE_BLINK  = 2'd2;
    localparam mode_t MODE_BREATH = 2'd3;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_ON,
        ST_BLINK,
        ST_BR_UP,
        ST_BR_DN,
        ST_DRAIN
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic state_e mode_entry_state(input mode_t m);
        case (m)
            MODE_ON:     return ST_ON;
            MODE_BLINK:  return ST_BLINK;
            MODE_BREATH: return ST_BR_UP;
            default:     return ST_OFF;
        endcase
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Free-running PWM timebase: a tick prescaler feeding a position counter
// that spans one PWM period.
module pwm_timebase
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int PWM_STEPS = 1000,
    localparam int POS_W    = cnt_width(PWM_STEPS)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    output logic [POS_W-1:0] pos,
    output logic             tick,
    output logic             period_end
);

    localparam int TDIV_W = cnt_width(TICK_DIV);
    localparam logic [TDIV_W-1:0] TICK_LAST = TDIV_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(PWM_STEPS - 1);

    logic [TDIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [POS_W-1:0]  pos_q, pos_d;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        period_end = tick && (pos_q == POS_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TDIV_W'(1);
        pos_d      = pos_q;
        if (tick) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt_q <= '0;
            pos_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pos_q      <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Status LED mode controller: accepts OFF/ON/BLINK/BREATH commands and
// switches modes only on PWM period boundaries, draining BREATH to dark first.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV      = 100,
    parameter int PWM_STEPS     = 1000,
    parameter int BLINK_PERIODS = 250
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    output logic [1:0] mode_o,
    output logic       led
);

    localparam int POS_W   = cnt_width(PWM_STEPS);
    localparam int DUTY_W  = $clog2(PWM_STEPS + 1);
    localparam int BLINK_W = cnt_width(BLINK_PERIODS);

    localparam logic [DUTY_W-1:0]  DUTY_FULL  = DUTY_W'(PWM_STEPS);
    localparam logic [DUTY_W-1:0]  DUTY_NEAR  = DUTY_W'(PWM_STEPS - 1);
    localparam logic [DUTY_W-1:0]  DUTY_ONE   = DUTY_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);

    logic [POS_W-1:0] pos;
    logic             tick;
    logic             period_end;

    pwm_timebase #(
        .TICK_DIV  (TICK_DIV),
        .PWM_STEPS (PWM_STEPS)
    ) u_timebase (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pos        (pos),
        .tick       (tick),
        .period_end (period_end)
    );

    state_e             state_q, state_d;
    mode_t              mode_q, mode_d;
    mode_t              pend_mode_q, pend_mode_d;
    logic               pend_q, pend_d;
    logic               ready_q, ready_d;
    logic               led_q, led_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    logic accept;
    logic boundary;
    logic breathing;
    logic enter;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;
        duty_d      = duty_q;
        blink_cnt_d = blink_cnt_q;
        enter       = 1'b0;

        accept    = cmd_valid && ready_q;
        boundary  = tick && period_end;
        breathing = (state_q == ST_BR_UP) || (state_q == ST_BR_DN);

        if (boundary) begin
            if (state_q == ST_DRAIN) begin
                if (duty_q != '0) begin
                    duty_d = duty_q - DUTY_ONE;
                end else begin
                    enter = 1'b1;
                end
            end else if (pend_q && (pend_mode_q != mode_q)) begin
                if (breathing && (duty_q != '0)) begin
                    state_d = ST_DRAIN;
                end else begin
                    enter = 1'b1;
                end
            end else begin
                // Re-requesting the running mode just retires the command;
                // the mode keeps its own rhythm undisturbed.
                pend_d = 1'b0;
                case (state_q)
                    ST_BLINK: begin
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_d = '0;
                            duty_d      = (duty_q == '0) ? DUTY_FULL : '0;
                        end else begin
                            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                        end
                    end
                    ST_BR_UP: begin
                        duty_d = duty_q + DUTY_ONE;
                        if (duty_q == DUTY_NEAR) begin
                            state_d = ST_BR_DN;
                        end
                    end
                    ST_BR_DN: begin
                        duty_d = duty_q - DUTY_ONE;
                        if (duty_q == DUTY_ONE) begin
                            state_d = ST_BR_UP;
                        end
                    end
                    default: ;
                endcase
            end

            if (enter) begin
                state_d     = mode_entry_state(pend_mode_q);
                mode_d      = pend_mode_q;
                pend_d      = 1'b0;
                blink_cnt_d = '0;
                duty_d      = ((pend_mode_q == MODE_ON) || (pend_mode_q == MODE_BLINK))
                              ? DUTY_FULL : '0;
            end
        end

        // Only accepted while idle, so this never collides with an apply.
        if (accept) begin
            pend_d      = 1'b1;
            pend_mode_d = cmd_mode;
        end

        ready_d = !pend_d && (state_d != ST_DRAIN);
        led_d   = DUTY_W'(pos) < duty_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_OFF;
            mode_q      <= MODE_OFF;
            pend_mode_q <= MODE_OFF;
            pend_q      <= 1'b0;
            ready_q     <= 1'b1;
            led_q       <= 1'b0;
            duty_q      <= '0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            ready_q     <= ready_d;
            led_q       <= led_d;
            duty_q      <= duty_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign cmd_ready = ready_q;
    assign mode_o    = mode_q;
    assign led       = led_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: a period-level model predicts mode and
// lit-cycle count per PWM period; a monitor measures the DUT and compares.
module tb_led_mode_ctrl;

    localparam int TD  = 2;
    localparam int NS  = 4;
    localparam int BP  = 2;
    localparam int PER = TD * NS;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode  = 2'd0;
    logic       cmd_ready;
    logic [1:0] mode_o;
    logic       led;

    always #5 sys_clk = ~sys_clk;

    led_mode_ctrl #(
        .TICK_DIV      (TD),
        .PWM_STEPS     (NS),
        .BLINK_PERIODS (BP)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_mode  (cmd_mode),
        .cmd_ready (cmd_ready),
        .mode_o    (mode_o),
        .led       (led)
    );

    int checks = 0;
    int errors = 0;
    bit tb_live = 1'b0;
    int cyc;

    // Cycles since reset release; cycle c covers the interval after edge c-1.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    typedef struct {
        int period;
        int mode;
        int highs;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model, one step per PWM period ----------------
    typedef enum int {B_OFF, B_ON, B_BLINK, B_BREATH, B_DRAIN} beh_e;
    beh_e m_beh;
    int   m_mode, m_phase, m_drain_duty, m_pend_mode, mcyc;
    bit   m_pend;

    function automatic int m_duty();
        case (m_beh)
            B_ON:     return NS;
            B_BLINK:  return (m_phase < BP) ? NS : 0;
            B_BREATH: return (m_phase <= NS) ? m_phase : 2 * NS - m_phase;
            B_DRAIN:  return m_drain_duty;
            default:  return 0;
        endcase
    endfunction

    function automatic bit m_ready();
        return !m_pend && (m_beh != B_DRAIN);
    endfunction

    function automatic void model_enter(input int md);
        m_mode  = md;
        m_pend  = 1'b0;
        m_phase = 0;
        case (md)
            1:       m_beh = B_ON;
            2:       m_beh = B_BLINK;
            3:       m_beh = B_BREATH;
            default: m_beh = B_OFF;
        endcase
    endfunction

    function automatic void model_period_end();
        if (m_beh == B_DRAIN) begin
            if (m_drain_duty > 0) m_drain_duty--;
            else                  model_enter(m_pend_mode);
        end else if (m_pend && m_pend_mode != m_mode) begin
            if (m_beh == B_BREATH && m_duty() > 0) begin
                m_drain_duty = m_duty();
                m_beh        = B_DRAIN;
            end else begin
                model_enter(m_pend_mode);
            end
        end else begin
            m_pend = 1'b0;
            if (m_beh == B_BLINK)  m_phase = (m_phase + 1) % (2 * BP);
            if (m_beh == B_BREATH) m_phase = (m_phase + 1) % (2 * NS);
        end
    endfunction

    function automatic void push_expected(input int p);
        exp_t e;
        e.period = p;
        e.mode   = m_mode;
        e.highs  = TD * m_duty();
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_beh        = B_OFF;
        m_mode       = 0;
        m_phase      = 0;
        m_drain_duty = 0;
        m_pend       = 1'b0;
        m_pend_mode  = 0;
        mcyc         = 0;
        exp_q.delete();
        push_expected(0);
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input bit issue, input int md);
        if (issue) begin
            cmd_valid = 1'b1;
            cmd_mode  = 2'(md);
        end
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        if (mcyc % PER == PER - 1) begin
            model_period_end();
            push_expected(mcyc / PER + 1);
        end
        if (issue) begin
            m_pend      = 1'b1;
            m_pend_mode = md;
        end
        mcyc++;
        check("cmd_ready", int'(cmd_ready), int'(m_ready()));
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("reset_led", int'(led), 0);
        check("reset_mode", int'(mode_o), 0);
        check("reset_ready", int'(cmd_ready), 1);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!m_ready() && k < 2000) begin
            step(1'b0, 0);
            k++;
        end
        if (!m_ready()) check("ready_timeout", 0, 1);
    endtask

    initial begin
        @(posedge sys_clk);
        #1;
        do_reset();
        tb_live = 1'b1;

        // Idle after reset: dark, OFF, ready.
        repeat (40) step(1'b0, 0);

        // ON issued in cycle 3 of a fresh timeline.
        do_reset();
        repeat (3) step(1'b0, 0);
        step(1'b1, 1);
        repeat (40) step(1'b0, 0);

        // BLINK for several half-cycles.
        wait_ready();
        step(1'b1, 2);
        repeat (80) step(1'b0, 0);

        // BREATH, then OFF requested during the duty-3 rising period.
        wait_ready();
        step(1'b1, 3);
        begin
            int k = 0;
            while (!(m_beh == B_BREATH && m_phase == 3 && mcyc % PER == 0) && k < 500) begin
                step(1'b0, 0);
                k++;
            end
            if (k >= 500) check("breath_timeout", 0, 1);
        end
        step(1'b1, 0);
        begin
            int k = 0;
            while (m_beh != B_DRAIN && k < 100) begin
                step(1'b0, 0);
                k++;
            end
            if (m_beh != B_DRAIN) check("drain_timeout", 0, 1);
        end
        repeat (PER + 3) step(1'b0, 0);

        // Reset in the middle of the drain, then ON right after release.
        do_reset();
        step(1'b1, 1);
        repeat (30) step(1'b0, 0);

        // Full BREATH drain to OFF, observed end to end.
        wait_ready();
        step(1'b1, 3);
        repeat (6 * PER) step(1'b0, 0);
        wait_ready();
        step(1'b1, 0);
        wait_ready();
        repeat (2 * PER) step(1'b0, 0);

        // Randomized command stream at arbitrary cycle offsets.
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 30)) step(1'b0, 0);
            wait_ready();
            step(1'b1, int'($urandom_range(0, 3)));
        end
        repeat (3 * PER) step(1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- monitor: one comparison set per PWM period ----------------
    initial begin
        int  win_cnt  = 0;
        int  win_mode = 0;
        bit  win_on   = 1'b0;
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n || !tb_live) begin
                win_on = 1'b0;
            end else begin
                if (cyc % PER == 1) begin
                    win_on   = 1'b1;
                    win_cnt  = 0;
                    win_mode = int'(mode_o);
                end
                if (win_on) begin
                    win_cnt += int'(led);
                    if (cyc % PER == 0) begin
                        win_on = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("scoreboard_empty", 0, 1);
                        end else begin
                            e = exp_q.pop_front();
                            check("period_index", cyc / PER - 1, e.period);
                            check("mode_o", win_mode, e.mode);
                            check("led_high_cycles", win_cnt, e.highs);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Mode controller for the board status LED. It accepts mode commands (OFF, ON, BLINK, BREATH) over a valid/ready handshake and sequences a shared PWM timebase. It drives a single registered LED output, replacing the fixed breathing-only LED block at the top level. Mode changes are applied only on PWM period boundaries. Leaving BREATH first ramps the duty down to zero, so the LED never steps visibly.

## Interface
- TICK_DIV, 100: sys_clk cycles per PWM step (2 µs at 50 MHz)
- PWM_STEPS, 1000: PWM steps per PWM period; also the duty full-scale value
- BLINK_PERIODS, 250: PWM periods per blink half-cycle
- sys_clk  in  1  system clock; single clock domain, all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_mode  in  2  requested mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATH
- cmd_ready  out  1  command can be accepted; reset 1
- mode_o  out  2  currently applied mode; reset 0 (OFF)
- led  out  1  registered LED drive, 1 = lit; reset 0

## Operation
- Timebase:
  - tick_cnt runs 0..TICK_DIV-1 and is free-running; tick = (tick_cnt == TICK_DIV-1).
  - pos runs 0..PWM_STEPS-1 and advances on tick.
  - period_end = tick && pos == PWM_STEPS-1.
- Duty: register, 0..PWM_STEPS, width clog2(PWM_STEPS+1). led <= (pos < duty).
- States:
  - OFF: duty 0.
  - ON: duty PWM_STEPS.
  - BLINK: duty alternates PWM_STEPS / 0.
  - BR_UP, BR_DN: breathing ramp.
  - DRAIN: ramp down before leaving BREATH.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - On accept, cmd_mode is latched into pend_mode, pend is set, and cmd_ready drops on the next cycle.
  - cmd_ready stays 0 while pend is set or the state is DRAIN.
  - cmd_ready rises the cycle after the pending mode is applied.
- Apply, at the first period_end with pend set:
  - If pend_mode equals mode_o: no change, no restart, pend cleared.
  - If the state is BR_UP/BR_DN, pend_mode != BREATH, and duty > 0: go to DRAIN and keep pend.
  - Otherwise enter pend_mode and clear pend:
    - OFF: duty 0.
    - ON: duty PWM_STEPS.
    - BLINK: duty PWM_STEPS, blink_cnt 0.
    - BREATH: duty 0, BR_UP.
  - mode_o updates in the same cycle the state is entered.
- BR_UP, at period_end: duty+1. When duty becomes PWM_STEPS, go to BR_DN.
- BR_DN, at period_end: duty-1. When duty becomes 0, go to BR_UP.
- A full breath is 2·PWM_STEPS periods (4 s at defaults).
- BLINK, at period_end:
  - blink_cnt+1.
  - At BLINK_PERIODS-1, blink_cnt wraps to 0 and duty toggles between PWM_STEPS and 0.
- DRAIN, at period_end:
  - duty-1.
  - When duty reaches 0, enter pend_mode in the next apply step, which is the same period_end evaluation chain: duty==1 → 0, then pend_mode applies at the following period_end.
  - mode_o stays 3 during DRAIN.
- Boundary rules:
  - duty never exceeds PWM_STEPS or goes below 0.
  - Both duty 0 and pos 0 give led 0.
  - A command arriving in the same cycle as period_end is latched only; it applies at the next period_end.
- Reset, asynchronous, also mid-ramp or mid-drain:
  - State OFF, duty 0, counters 0, pend 0, cmd_ready 1, mode_o 0, led 0.
  - Normal operation resumes on the first edge after release.

## Timing
- Command-to-apply latency: from 1 cycle up to one PWM period (TICK_DIV·PWM_STEPS cycles) after accept, plus drain time when leaving BREATH.
- led lags the (pos, duty) change by 1 cycle.
- Exactly one command can be outstanding at a time.

## Structure
- Package led_ctrl_pkg:
  - Mode encodings MODE_OFF/ON/BLINK/BREATH.
  - State enum {OFF, ON, BLINK, BR_UP, BR_DN, DRAIN}.
- Sub-module pwm_timebase:
  - Parameters TICK_DIV, PWM_STEPS.
  - Outputs pos, tick, period_end.
  - Shares sys_clk/sys_rst_n.
- The top level holds the FSM, duty, blink_cnt, pend logic and the led register.

## Test plan
All scenarios use TICK_DIV=2, PWM_STEPS=4, BLINK_PERIODS=2, so one PWM period is 8 cycles.
- Reset release, no commands → led 0, mode_o 0, cmd_ready 1 indefinitely.
- Command ON at cycle 3 → cmd_ready 0 until period_end at cycle 7; mode_o=1 from cycle 8; led 1 continuously from cycle 9.
- Command BLINK → led is high for 16 cycles and low for 16 cycles, repeating; mode_o=2.
- Command BREATH → duty steps 0,1,2,3,4,3,2,1,0 at successive period_ends; led high-count per period matches duty.
- Command OFF at duty 3 in BR_UP → DRAIN; duty goes 3,2,1,0 over 3 periods; then mode_o=0; cmd_ready held 0 throughout, then returns to 1.
- Assert sys_rst_n low mid-DRAIN for 1 cycle → outputs reset immediately; a new ON command is accepted right after release.
